dmem_access_ctrl: RTL and testbench

- Memory-stage sequencer for data-memory loads and stores.
- Consumes the byte/halfword/word read/write control flags produced by instruction decode and carried down the pipeline.
- Drives a word-wide data-memory port with a req/ack handshake, stalls the pipeline until the access completes, and returns sign- or zero-extended load data.
- Detects misaligned accesses and bus timeouts.

---
 rtl/dmem_access_ctrl_pkg.sv | 39 +++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/dmem_access_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller.
//   size_e  : access size encoding (byte / half / word)
//   state_e : sequencer state encoding
//   size_decode : one-hot-ish size flags to size_e, word > half > byte, none = word
//   is_aligned  : natural-alignment check for a size at a byte offset
package dmem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic size_e size_decode(input logic b, input logic h, input logic w);
      size_e sz;
      if (w)      sz = SZ_WORD;
      else if (h) sz = SZ_HALF;
      else if (b) sz = SZ_BYTE;
      else        sz = SZ_WORD;
      return sz;
   endfunction

   function automatic logic is_aligned(input size_e sz, input logic [1:0] ofs);
      logic ok;
      case (sz)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~ofs[0];
         default: ok = (ofs == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for a 32-bit little-endian data-memory port.
//   i_size   : access size
//   i_lane   : byte offset within the word (addr[1:0])
//   i_signed : sign-extend the read result
//   i_wdata  : right-aligned store data
//   i_rdata  : raw word read from memory
//   o_be     : byte enables for the access
//   o_wdata  : store data replicated across all lanes
//   o_rdata  : selected lane, extended to 32 bits
module dmem_lane_align
   import dmem_access_ctrl_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = i_rdata[{i_lane, 3'b000} +: 8];
      half_sel = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_be     = 4'b1111;
      o_wdata  = i_wdata;
      o_rdata  = i_rdata;
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_lane;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_signed & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{i_signed & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer for data-memory loads and stores.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a load/store; aligned access latched, misaligned flagged
// ST_REQ  | o_dm_req held with stable latched address/data until ack or timeout
// ST_DONE | one cycle: pipeline released, load data / bus error presented
//
// Ports:
//   i_clk, i_rst            : clock, async active-high reset
//   i_mem_rd, i_mem_wr      : load / store in MEM stage (read wins if both)
//   i_*byte_rd, i_signed_mem_rd : load size and sign flags
//   i_*byte_wr              : store size flags
//   i_addr, i_wdata         : effective address, right-aligned store data
//   i_dm_ack, i_dm_rdata    : memory completion and read word
//   o_dm_*                  : memory request port (word address, lane enables)
//   o_stall                 : hold upstream pipeline registers
//   o_rdata, o_rdata_vld    : extended load result and its one-cycle valid
//   o_misaligned, o_bus_err : one-cycle error pulses
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_rd,
   input  logic        i_mem_wr,
   input  logic        i_byte_rd,
   input  logic        i_2byte_rd,
   input  logic        i_4byte_rd,
   input  logic        i_signed_mem_rd,
   input  logic        i_byte_wr,
   input  logic        i_2byte_wr,
   input  logic        i_4byte_wr,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_dm_ack,
   input  logic [31:0] i_dm_rdata,
   output logic        o_dm_req,
   output logic        o_dm_we,
   output logic [3:0]  o_dm_be,
   output logic [31:0] o_dm_addr,
   output logic [31:0] o_dm_wdata,
   output logic        o_stall,
   output logic [31:0] o_rdata,
   output logic        o_rdata_vld,
   output logic        o_misaligned,
   output logic        o_bus_err
);

   localparam bit              TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [29:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   size_e             size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              req_q, req_d;
   logic              vld_q, vld_d;
   logic              bus_err_q, bus_err_d;

   logic              valid;
   logic              aligned;
   logic              idle_go;
   size_e             in_size;
   size_e             al_size;
   logic [1:0]        al_lane;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata;
   logic [31:0]       al_rdata;

   always_comb begin
      valid   = i_mem_rd | i_mem_wr;
      in_size = i_mem_rd ? size_decode(i_byte_rd, i_2byte_rd, i_4byte_rd)
                         : size_decode(i_byte_wr, i_2byte_wr, i_4byte_wr);
      aligned = is_aligned(in_size, i_addr[1:0]);
      idle_go = (state_q == ST_IDLE) & valid & aligned;
      // One aligner serves both directions: live inputs in IDLE for the
      // write lanes, latched size/lane in REQ for read shaping.
      al_size = (state_q == ST_IDLE) ? in_size : size_q;
      al_lane = (state_q == ST_IDLE) ? i_addr[1:0] : lane_q;
   end

   dmem_lane_align u_align (
      .i_size   (al_size),
      .i_lane   (al_lane),
      .i_signed (sgn_q),
      .i_wdata  (i_wdata),
      .i_rdata  (i_dm_rdata),
      .o_be     (al_be),
      .o_wdata  (al_wdata),
      .o_rdata  (al_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      size_d    = size_q;
      sgn_d     = sgn_q;
      lane_d    = lane_q;
      rdata_d   = rdata_q;
      req_d     = req_q;
      vld_d     = 1'b0;
      bus_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (idle_go) begin
               addr_d  = i_addr[31:2];
               be_d    = al_be;
               wdata_d = al_wdata;
               we_d    = ~i_mem_rd;
               size_d  = in_size;
               sgn_d   = i_signed_mem_rd;
               lane_d  = i_addr[1:0];
               cnt_d   = '0;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (i_dm_ack) begin
               if (!we_q) rdata_d = al_rdata;
               vld_d   = ~we_q;
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               rdata_d   = '0;
               bus_err_d = 1'b1;
               req_d     = 1'b0;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         size_q    <= SZ_BYTE;
         sgn_q     <= 1'b0;
         lane_q    <= '0;
         rdata_q   <= '0;
         req_q     <= 1'b0;
         vld_q     <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         size_q    <= size_d;
         sgn_q     <= sgn_d;
         lane_q    <= lane_d;
         rdata_q   <= rdata_d;
         req_q     <= req_d;
         vld_q     <= vld_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Stall and misalignment look at live inputs in IDLE; reset gates them so
   // they fall together with the abandoned request.
   assign o_stall      = ~i_rst & (idle_go | (state_q == ST_REQ));
   assign o_misaligned = ~i_rst & (state_q == ST_IDLE) & valid & ~aligned;

   assign o_dm_req    = req_q;
   assign o_dm_we     = we_q;
   assign o_dm_be     = be_q;
   assign o_dm_addr   = {addr_q, 2'b00};
   assign o_dm_wdata  = wdata_q;
   assign o_rdata     = rdata_q;
   assign o_rdata_vld = vld_q;
   assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with directed and random accesses.
module tb_dmem_access_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_mem_rd, i_mem_wr;
   logic        i_byte_rd, i_2byte_rd, i_4byte_rd, i_signed_mem_rd;
   logic        i_byte_wr, i_2byte_wr, i_4byte_wr;
   logic [31:0] i_addr, i_wdata;
   logic        i_dm_ack;
   logic [31:0] i_dm_rdata;
   logic        o_dm_req, o_dm_we;
   logic [3:0]  o_dm_be;
   logic [31:0] o_dm_addr, o_dm_wdata;
   logic        o_stall;
   logic [31:0] o_rdata;
   logic        o_rdata_vld, o_misaligned, o_bus_err;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_hold;

   localparam int TO_CYC = 16;

   always #5 i_clk = ~i_clk;

   dmem_access_ctrl dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_mem_rd        (i_mem_rd),
      .i_mem_wr        (i_mem_wr),
      .i_byte_rd       (i_byte_rd),
      .i_2byte_rd      (i_2byte_rd),
      .i_4byte_rd      (i_4byte_rd),
      .i_signed_mem_rd (i_signed_mem_rd),
      .i_byte_wr       (i_byte_wr),
      .i_2byte_wr      (i_2byte_wr),
      .i_4byte_wr      (i_4byte_wr),
      .i_addr          (i_addr),
      .i_wdata         (i_wdata),
      .i_dm_ack        (i_dm_ack),
      .i_dm_rdata      (i_dm_rdata),
      .o_dm_req        (o_dm_req),
      .o_dm_we         (o_dm_we),
      .o_dm_be         (o_dm_be),
      .o_dm_addr       (o_dm_addr),
      .o_dm_wdata      (o_dm_wdata),
      .o_stall         (o_stall),
      .o_rdata         (o_rdata),
      .o_rdata_vld     (o_rdata_vld),
      .o_misaligned    (o_misaligned),
      .o_bus_err       (o_bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int nbytes(input bit b, input bit h, input bit w);
      if (w) return 4;
      if (h) return 2;
      if (b) return 1;
      return 4;
   endfunction

   task automatic drive_idle();
      i_mem_rd = 0; i_mem_wr = 0;
      i_byte_rd = 0; i_2byte_rd = 0; i_4byte_rd = 0; i_signed_mem_rd = 0;
      i_byte_wr = 0; i_2byte_wr = 0; i_4byte_wr = 0;
      i_addr = '0; i_wdata = '0; i_dm_ack = 0; i_dm_rdata = '0;
   endtask

   // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
   task automatic run_txn(input bit rd, input bit wr,
                          input bit rb, input bit rh, input bit rw, input bit sg,
                          input bit wb, input bit wh, input bit ww,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int d, input bit to);
      int          nb, ofs, stall_cnt, i, exp_stall;
      bit          valid, ld, mis;
      int          be_i;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_rd, mask;

      i_mem_rd = rd; i_mem_wr = wr;
      i_byte_rd = rb; i_2byte_rd = rh; i_4byte_rd = rw; i_signed_mem_rd = sg;
      i_byte_wr = wb; i_2byte_wr = wh; i_4byte_wr = ww;
      i_addr = addr; i_wdata = wd; i_dm_ack = 0;
      #1;
      valid = rd | wr;
      ld    = rd;
      nb    = ld ? nbytes(rb, rh, rw) : nbytes(wb, wh, ww);
      ofs   = int'(addr % 4);
      if (!valid) begin
         chk("idle_stall", o_stall, 0);
         chk("idle_req", o_dm_req, 0);
         chk("idle_mis", o_misaligned, 0);
         @(posedge i_clk);
         @(negedge i_clk);
         return;
      end
      mis = (ofs % nb) != 0;
      if (mis) begin
         chk("mis_pulse", o_misaligned, 1);
         chk("mis_stall", o_stall, 0);
         chk("mis_req", o_dm_req, 0);
         @(posedge i_clk);
         @(negedge i_clk);
         drive_idle();
         chk("mis_req_after", o_dm_req, 0);
         return;
      end

      be_i   = ((1 << nb) - 1) << ofs;
      exp_be = be_i[3:0];
      mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (nb == 1)      exp_wd = (wd & 32'hFF) * 32'h0101_0101;
      else if (nb == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
      else              exp_wd = wd;
      exp_rd = (rdat >> (8 * ofs)) & mask;
      if (sg && nb < 4 && exp_rd[8 * nb - 1]) exp_rd = exp_rd | ~mask;

      chk("go_mis", o_misaligned, 0);
      chk("go_stall", o_stall, 1);
      chk("go_req", o_dm_req, 0);

      stall_cnt = 1;
      i = 0;
      @(posedge i_clk);
      while (i < 40) begin
         @(negedge i_clk);
         i_dm_ack = 0;
         if (!o_stall) break;
         stall_cnt++;
         chk("req", o_dm_req, 1);
         chk("req_addr", o_dm_addr, addr & 32'hFFFF_FFFC);
         chk("req_be", {28'd0, o_dm_be}, {28'd0, exp_be});
         chk("req_wdata", o_dm_wdata, exp_wd);
         chk("req_we", o_dm_we, !ld);
         if (!to && i == d) begin
            i_dm_ack   = 1;
            i_dm_rdata = rdat;
         end else begin
            i_dm_rdata = $urandom;
         end
         i++;
      end
      exp_stall = to ? (1 + TO_CYC) : (2 + d);
      chk("stall_cycles", stall_cnt, exp_stall);
      if (to)      exp_hold = '0;
      else if (ld) exp_hold = exp_rd;
      chk("done_req", o_dm_req, 0);
      chk("done_vld", o_rdata_vld, ld && !to);
      chk("done_buserr", o_bus_err, to);
      chk("done_rdata", o_rdata, exp_hold);
      @(posedge i_clk);
      @(negedge i_clk);
      chk("post_vld", o_rdata_vld, 0);
      chk("post_buserr", o_bus_err, 0);
      chk("post_rdata", o_rdata, exp_hold);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      drive_idle();
      exp_hold = '0;
      i_rst = 1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_req", o_dm_req, 0);
      chk("rst_stall", o_stall, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_vld", o_rdata_vld, 0);
      chk("rst_buserr", o_bus_err, 0);
      chk("rst_be", {28'd0, o_dm_be}, 0);
      chk("rst_addr", o_dm_addr, 0);
      i_rst = 0;
      @(negedge i_clk);

      // lb, signed, ack on first REQ cycle
      run_txn(1, 0, 1, 0, 0, 1, 0, 0, 0, 32'h1003, 0, 32'h80FF_FF7F, 0, 0);
      chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
      // lhu, three wait cycles
      run_txn(1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h2002, 0, 32'h8001_1234, 3, 0);
      chk("lhu_rdata", o_rdata, 32'h0000_8001);
      // sb
      run_txn(0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h11, 32'hA5, 0, 0, 0);
      // sw misaligned
      run_txn(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h6, 32'h1234_5678, 0, 0, 1);
      // lw with no ack -> timeout
      run_txn(1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 0, 0, 0, 1);

      // reset in the middle of REQ
      i_mem_rd = 1; i_4byte_rd = 1; i_addr = 32'h80;
      @(posedge i_clk);
      repeat (3) @(negedge i_clk);
      chk("pre_rst_req", o_dm_req, 1);
      i_rst = 1;
      #1;
      chk("async_rst_req", o_dm_req, 0);
      chk("async_rst_stall", o_stall, 0);
      exp_hold = '0;
      @(negedge i_clk);
      i_rst = 0;
      drive_idle();
      @(negedge i_clk);
      run_txn(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, 1, 0);

      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 a, $urandom, $urandom, $urandom_range(0, 4),
                 $urandom_range(0, 19) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
